// File: rtl/guvm_wb_pkg.sv
// Shared constants and FSM state encoding for the Wishbone stub slave.
package guvm_wb_pkg;

  localparam logic [31:0] NOP_FILLER = 32'hF0801003;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    TERM = 2'd2
  } wb_state_e;

endpackage

// File: rtl/guvm_sync_fifo.sv
// Single-clock FIFO with an extra pointer bit so a full queue is distinguishable from an empty one.
// Push is ignored when full and pop is ignored when empty; there is no bypass path.
module guvm_sync_fifo #(
  parameter int DW    = 32,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [DW-1:0]            wdata,
  input  logic                     pop,
  output logic [DW-1:0]            rdata,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [AW:0]   wptr;
  logic [AW:0]   rptr;
  logic          full;
  logic          empty;
  logic          do_push;
  logic          do_pop;

  assign count   = wptr - rptr;
  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/guvm_wb_stub_slave.sv
// Wishbone classic slave standing in for memory: reads come from an injection FIFO,
// writes land in a capture FIFO, with programmable wait states and one-shot error termination.
module guvm_wb_stub_slave
  import guvm_wb_pkg::*;
#(
  parameter int WB_DW     = 128,
  parameter int INJ_DEPTH = 8,
  parameter int CAP_DEPTH = 8,
  parameter int WAIT_W    = 4
) (
  input  logic                           i_clk,
  input  logic                           i_rst_n,
  input  logic [31:0]                    i_wb_adr,
  input  logic [WB_DW/8-1:0]             i_wb_sel,
  input  logic                           i_wb_we,
  input  logic [WB_DW-1:0]               i_wb_dat,
  output logic [WB_DW-1:0]               o_wb_dat,
  input  logic                           i_wb_cyc,
  input  logic                           i_wb_stb,
  output logic                           o_wb_ack,
  output logic                           o_wb_err,
  input  logic                           i_inj_valid,
  input  logic [31:0]                    i_inj_inst,
  output logic                           o_inj_ready,
  output logic [$clog2(INJ_DEPTH):0]     o_inj_count,
  output logic                           o_cap_valid,
  output logic [31:0]                    o_cap_adr,
  output logic [31:0]                    o_cap_dat,
  input  logic                           i_cap_ready,
  input  logic [WAIT_W-1:0]              i_wait_cycles,
  input  logic                           i_err_arm,
  output logic                           o_underflow,
  output logic                           o_overflow
);

  localparam int LANES  = WB_DW / 32;
  localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int INJ_CW = $clog2(INJ_DEPTH) + 1;
  localparam int CAP_CW = $clog2(CAP_DEPTH) + 1;

  wb_state_e         state;
  logic [WAIT_W-1:0] cnt;
  logic              armed;
  logic [31:0]       adr_q;
  logic              we_q;
  logic [LANE_W-1:0] lane_q;
  logic [31:0]       wword_q;
  logic [3:0]        wsel_q;

  logic              start;
  logic              term_now;
  logic [LANE_W-1:0] in_lane;
  logic [31:0]       cur_adr;
  logic              cur_we;
  logic [LANE_W-1:0] cur_lane;
  logic [31:0]       cur_word;
  logic [3:0]        cur_sel;
  logic              rd_term;
  logic              wr_term;
  logic [WB_DW-1:0]  rd_data;

  logic [31:0]       inj_head;
  logic              inj_empty;
  logic              inj_pop;
  logic              cap_push;
  logic [63:0]       cap_head;
  logic [CAP_CW-1:0] cap_count;
  logic              cap_full;

  assign start   = (state == IDLE) && i_wb_cyc && i_wb_stb;
  assign in_lane = LANE_W'((i_wb_adr >> 2) & 32'(LANES - 1));

  // A zero-wait transaction terminates on the same edge that samples it, so the
  // live bus is used in IDLE and the latched copy afterwards.
  assign term_now = (start && (i_wait_cycles == '0)) ||
                    ((state == WAIT) && i_wb_cyc && (cnt == WAIT_W'(1)));
  assign cur_adr  = (state == IDLE) ? i_wb_adr : adr_q;
  assign cur_we   = (state == IDLE) ? i_wb_we  : we_q;
  assign cur_lane = (state == IDLE) ? in_lane  : lane_q;
  assign cur_word = (state == IDLE) ? i_wb_dat[in_lane*32 +: 32] : wword_q;
  assign cur_sel  = (state == IDLE) ? i_wb_sel[in_lane*4 +: 4]   : wsel_q;

  assign rd_term  = term_now & ~cur_we & ~armed;
  assign wr_term  = term_now &  cur_we & ~armed;
  assign inj_pop  = rd_term & ~inj_empty;
  assign cap_push = wr_term & (|cur_sel);

  assign inj_empty   = (o_inj_count == '0);
  assign o_inj_ready = (o_inj_count != INJ_CW'(INJ_DEPTH));
  assign cap_full    = (cap_count == CAP_CW'(CAP_DEPTH));
  assign o_cap_valid = (cap_count != '0);
  assign o_cap_adr   = cap_head[63:32];
  assign o_cap_dat   = cap_head[31:0];

  always_comb begin
    rd_data = '0;
    for (int l = 0; l < LANES; l++) begin
      rd_data[l*32 +: 32] = ((LANE_W'(l) == cur_lane) && !inj_empty) ? inj_head : NOP_FILLER;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      armed       <= 1'b0;
      o_wb_ack    <= 1'b0;
      o_wb_err    <= 1'b0;
      o_wb_dat    <= '0;
      o_underflow <= 1'b0;
      o_overflow  <= 1'b0;
    end else begin
      o_wb_ack <= term_now & ~armed;
      o_wb_err <= term_now &  armed;
      armed    <= (armed & ~term_now) | i_err_arm;
      if (rd_term)              o_wb_dat    <= rd_data;
      if (rd_term && inj_empty) o_underflow <= 1'b1;
      if (cap_push && cap_full) o_overflow  <= 1'b1;
      case (state)
        IDLE: if (start) begin
          cnt   <= i_wait_cycles;
          state <= (i_wait_cycles == '0) ? TERM : WAIT;
        end
        WAIT: if (!i_wb_cyc) begin
          state <= IDLE;
        end else begin
          cnt <= cnt - WAIT_W'(1);
          if (cnt == WAIT_W'(1)) state <= TERM;
        end
        TERM:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (start) begin
      adr_q   <= i_wb_adr;
      we_q    <= i_wb_we;
      lane_q  <= in_lane;
      wword_q <= i_wb_dat[in_lane*32 +: 32];
      wsel_q  <= i_wb_sel[in_lane*4 +: 4];
    end
  end

  guvm_sync_fifo #(.DW(32), .DEPTH(INJ_DEPTH)) u_inj_fifo (
    .clk   (i_clk),
    .rst_n (i_rst_n),
    .push  (i_inj_valid),
    .wdata (i_inj_inst),
    .pop   (inj_pop),
    .rdata (inj_head),
    .count (o_inj_count)
  );

  guvm_sync_fifo #(.DW(64), .DEPTH(CAP_DEPTH)) u_cap_fifo (
    .clk   (i_clk),
    .rst_n (i_rst_n),
    .push  (cap_push),
    .wdata ({cur_adr, cur_word}),
    .pop   (i_cap_ready),
    .rdata (cap_head),
    .count (cap_count)
  );

endmodule

// File: tb/tb_guvm_wb_stub_slave.sv
// Directed bench for guvm_wb_stub_slave: a vector table for single transactions plus
// hand-written sequences for overflow, error arming, abort, back-to-back and reset.
module tb_guvm_wb_stub_slave;

  localparam logic [31:0] NOP = 32'hF0801003;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [31:0]  wb_adr = '0;
  logic [15:0]  wb_sel = '0;
  logic         wb_we = 1'b0;
  logic [127:0] wb_dat_w = '0;
  logic [127:0] wb_dat_r;
  logic         wb_cyc = 1'b0;
  logic         wb_stb = 1'b0;
  logic         wb_ack;
  logic         wb_err;
  logic         inj_valid = 1'b0;
  logic [31:0]  inj_inst = '0;
  logic         inj_ready;
  logic [3:0]   inj_count;
  logic         cap_valid;
  logic [31:0]  cap_adr;
  logic [31:0]  cap_dat;
  logic         cap_ready = 1'b0;
  logic [3:0]   wait_cycles = '0;
  logic         err_arm = 1'b0;
  logic         underflow;
  logic         overflow;

  int checks = 0;
  int failures = 0;

  guvm_wb_stub_slave #(.WB_DW(128), .INJ_DEPTH(8), .CAP_DEPTH(8), .WAIT_W(4)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_wb_adr(wb_adr), .i_wb_sel(wb_sel), .i_wb_we(wb_we),
    .i_wb_dat(wb_dat_w), .o_wb_dat(wb_dat_r), .i_wb_cyc(wb_cyc), .i_wb_stb(wb_stb),
    .o_wb_ack(wb_ack), .o_wb_err(wb_err), .i_inj_valid(inj_valid), .i_inj_inst(inj_inst),
    .o_inj_ready(inj_ready), .o_inj_count(inj_count), .o_cap_valid(cap_valid),
    .o_cap_adr(cap_adr), .o_cap_dat(cap_dat), .i_cap_ready(cap_ready),
    .i_wait_cycles(wait_cycles), .i_err_arm(err_arm), .o_underflow(underflow),
    .o_overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         we;
    logic [31:0]  adr;
    logic [15:0]  sel;
    logic [127:0] wdat;
    logic [3:0]   wt;
    int           lat;
    logic [127:0] exp_dat;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic inject(input logic [31:0] w);
    @(negedge clk);
    inj_valid = 1'b1;
    inj_inst  = w;
    @(negedge clk);
    inj_valid = 1'b0;
  endtask

  task automatic arm_err();
    @(negedge clk);
    err_arm = 1'b1;
    @(negedge clk);
    err_arm = 1'b0;
  endtask

  task automatic cap_pop();
    @(negedge clk);
    cap_ready = 1'b1;
    @(negedge clk);
    cap_ready = 1'b0;
  endtask

  // Runs one transaction; lat counts cycles from the sampling edge to the terminating pulse.
  task automatic txn(input logic we, input logic [31:0] adr, input logic [15:0] sel,
                     input logic [127:0] wdat, input logic [3:0] wt,
                     output int lat, output logic got_err, output logic [127:0] dat);
    bit done = 0;
    lat = 0;
    got_err = 1'b0;
    dat = '0;
    @(negedge clk);
    wb_we = we; wb_adr = adr; wb_sel = sel; wb_dat_w = wdat; wait_cycles = wt;
    wb_cyc = 1'b1; wb_stb = 1'b1;
    for (int n = 1; n <= 40 && !done; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (wb_ack || wb_err) begin
        lat = n; got_err = wb_err; dat = wb_dat_r; done = 1;
      end
    end
    wb_cyc = 1'b0; wb_stb = 1'b0;
    chk("txn_terminated", done, 1'b1);
    @(negedge clk);
    chk("term_one_cycle", {wb_ack, wb_err}, 2'b00);
  endtask

  int           lat;
  logic         got_err;
  logic [127:0] dat;
  int           seen;

  initial begin
    vecs[0] = '{1'b0, 32'h0,  16'h0,    128'h0, 4'd0, 1, {NOP, NOP, NOP, 32'hE3A01005}};
    vecs[1] = '{1'b0, 32'h8,  16'h0,    128'h0, 4'd3, 4, {NOP, 32'hE1A00000, NOP, NOP}};
    vecs[2] = '{1'b0, 32'h4,  16'h0,    128'h0, 4'd1, 2, {NOP, NOP, NOP, NOP}};
    vecs[3] = '{1'b1, 32'h4,  16'h00F0, {32'h0, 32'h0, 32'h2A, 32'hDEAD}, 4'd0, 1, 128'h0};
    vecs[4] = '{1'b1, 32'hC,  16'h000F, {32'h77, 32'h0, 32'h0, 32'h0}, 4'd2, 3, 128'h0};
    vecs[5] = '{1'b1, 32'h10, 16'h000F, {32'h0, 32'h0, 32'h0, 32'h55}, 4'd0, 1, 128'h0};

    // Reset state
    #12;
    chk("rst_ack", wb_ack, 1'b0);
    chk("rst_err", wb_err, 1'b0);
    chk("rst_dat", wb_dat_r, 128'h0);
    chk("rst_inj_count", inj_count, 4'd0);
    chk("rst_inj_ready", inj_ready, 1'b1);
    chk("rst_cap_valid", cap_valid, 1'b0);
    chk("rst_stickies", {underflow, overflow}, 2'b00);
    @(negedge clk);
    rst_n = 1'b1;

    inject(32'hE3A01005);
    inject(32'hE1A00000);
    chk("inj_count_2", inj_count, 4'd2);

    for (int i = 0; i < 6; i++) begin
      txn(vecs[i].we, vecs[i].adr, vecs[i].sel, vecs[i].wdat, vecs[i].wt, lat, got_err, dat);
      chk($sformatf("v%0d_latency", i), lat, vecs[i].lat);
      chk($sformatf("v%0d_no_err", i), got_err, 1'b0);
      if (!vecs[i].we) chk($sformatf("v%0d_rdata", i), dat, vecs[i].exp_dat);
    end
    chk("post_inj_count", inj_count, 4'd0);
    chk("underflow_set", underflow, 1'b1);
    chk("overflow_clear", overflow, 1'b0);
    chk("cap0_valid", cap_valid, 1'b1);
    chk("cap0_adr", cap_adr, 32'h4);
    chk("cap0_dat", cap_dat, 32'h2A);
    cap_pop();
    chk("cap1_adr", cap_adr, 32'h10);
    chk("cap1_dat", cap_dat, 32'h55);
    cap_pop();
    chk("cap_empty_no_sel_push", cap_valid, 1'b0);

    // Capture overflow: eight fit, the ninth is dropped but still acked
    for (int i = 0; i < 8; i++)
      txn(1'b1, 32'(i * 16), 16'h000F, {96'h0, 32'(i)}, 4'd0, lat, got_err, dat);
    chk("ovf_before", overflow, 1'b0);
    txn(1'b1, 32'h100, 16'h000F, {96'h0, 32'h99}, 4'd0, lat, got_err, dat);
    chk("ovf_ack", {got_err, 8'(lat)}, {1'b0, 8'd1});
    chk("ovf_set", overflow, 1'b1);
    chk("ovf_head_adr", cap_adr, 32'h0);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("ovf_pop%0d_dat", i), cap_dat, 32'(i));
      cap_pop();
    end
    chk("ovf_drained", cap_valid, 1'b0);

    // One-shot error
    inject(32'h11111111);
    arm_err();
    txn(1'b0, 32'h0, 16'h0, 128'h0, 4'd0, lat, got_err, dat);
    chk("err_pulse", got_err, 1'b1);
    chk("err_dat_held", dat, {NOP, NOP, NOP, NOP});
    chk("err_no_pop", inj_count, 4'd1);
    txn(1'b0, 32'h0, 16'h0, 128'h0, 4'd0, lat, got_err, dat);
    chk("after_err_ack", got_err, 1'b0);
    chk("after_err_dat", dat, {NOP, NOP, NOP, 32'h11111111});

    // Abort in WAIT keeps the armed error and the queued word
    inject(32'h22222222);
    arm_err();
    @(negedge clk);
    wb_we = 1'b0; wb_adr = 32'h0; wait_cycles = 4'd5; wb_cyc = 1'b1; wb_stb = 1'b1;
    seen = 0;
    repeat (3) begin
      @(negedge clk);
      seen += int'(wb_ack | wb_err);
    end
    wb_cyc = 1'b0; wb_stb = 1'b0;
    repeat (8) begin
      @(negedge clk);
      seen += int'(wb_ack | wb_err);
    end
    chk("abort_no_term", seen, 0);
    chk("abort_no_pop", inj_count, 4'd1);
    txn(1'b0, 32'h0, 16'h0, 128'h0, 4'd0, lat, got_err, dat);
    chk("abort_err_retained", got_err, 1'b1);
    txn(1'b0, 32'h0, 16'h0, 128'h0, 4'd0, lat, got_err, dat);
    chk("abort_then_ack_dat", {got_err, dat}, {1'b0, NOP, NOP, NOP, 32'h22222222});

    // Strobe held high: every other cycle terminates
    @(negedge clk);
    wb_we = 1'b0; wait_cycles = 4'd0; wb_cyc = 1'b1; wb_stb = 1'b1;
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      seen += int'(wb_ack);
    end
    wb_cyc = 1'b0; wb_stb = 1'b0;
    chk("b2b_ack_count", seen, 3);

    // Async reset mid-termination
    inject(32'h33333333);
    @(negedge clk);
    wb_we = 1'b0; wb_adr = 32'h0; wait_cycles = 4'd0; wb_cyc = 1'b1; wb_stb = 1'b1;
    @(negedge clk);
    chk("pre_rst_ack", wb_ack, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_ack", wb_ack, 1'b0);
    chk("async_rst_inj_count", inj_count, 4'd0);
    chk("async_rst_dat", wb_dat_r, 128'h0);
    chk("async_rst_stickies", {underflow, overflow}, 2'b00);
    wb_cyc = 1'b0; wb_stb = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
